// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - SPI initiator reading the dual-channel 14-bit ADC and programming its preamp
//
// Purpose: runs preamp gain transfers (8 bits, MSB first, AMP_CS low) and ADC conversions
// (AD_CONV strobe, then 34 SCK periods capturing two 14-bit two's-complement samples).
// After reset the gain word GAIN_RESET is sent once automatically.
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   START      in   request one conversion (sampled only in IDLE)
//   GAIN[7:0]  in   preamp gain word, [7:4]=channel B, [3:0]=channel A
//   GAIN_LOAD  in   request a preamp gain transfer (sampled only in IDLE)
//   SPI_MISO   in   ADC serial data
//   SPI_SCK    out  SPI clock, idle low
//   SPI_MOSI   out  preamp serial data
//   AMP_CS     out  preamp chip select, active low
//   AMP_SHDN   out  preamp shutdown, held 0
//   AD_CONV    out  ADC conversion strobe
//   CH0/CH1    out  last published samples
//   VALID      out  one-cycle pulse when CH0/CH1 update
//   BUSY       out  high while a transfer is in progress
module adc_capture #(
    parameter int         CLK_DIV    = 4,
    parameter logic [7:0] GAIN_RESET = 8'h11
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [7:0]  GAIN,
    input  logic        GAIN_LOAD,
    input  logic        SPI_MISO,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        AMP_CS,
    output logic        AMP_SHDN,
    output logic        AD_CONV,
    output logic [13:0] CH0,
    output logic [13:0] CH1,
    output logic        VALID,
    output logic        BUSY
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_AMP_SHIFT = 3'd1;
    localparam logic [2:0] S_AMP_TAIL  = 3'd2;
    localparam logic [2:0] S_CONV      = 3'd3;
    localparam logic [2:0] S_ADC_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        phase_q, phase_d;      // 0 = SCK low half, 1 = SCK high half
    logic [5:0]  bit_q, bit_d;
    logic [7:0]  gain_q, gain_d;
    logic [7:0]  amp_sr_q, amp_sr_d;
    logic        gain_pend_q, gain_pend_d;
    logic        start_pend_q, start_pend_d;
    logic [13:0] sh0_q, sh0_d;
    logic [13:0] sh1_q, sh1_d;
    logic [13:0] ch0_q, ch0_d;
    logic [13:0] ch1_q, ch1_d;
    logic        valid_q, valid_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic        conv_q, conv_d;
    logic        busy_q, busy_d;
    logic        div_last;

    // Greater-or-equal so a corrupted counter can never run past its terminal count.
    assign div_last = (div_q >= DIV_LAST);

    always_comb begin
        state_d      = state_q;
        div_d        = div_q + 8'd1;
        phase_d      = phase_q;
        bit_d        = bit_q;
        gain_d       = gain_q;
        amp_sr_d     = amp_sr_q;
        gain_pend_d  = gain_pend_q;
        start_pend_d = start_pend_q;
        sh0_d        = sh0_q;
        sh1_d        = sh1_q;
        ch0_d        = ch0_q;
        ch1_d        = ch1_q;
        valid_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d   = 8'd0;
                phase_d = 1'b0;
                bit_d   = 6'd0;
                if (gain_pend_q || GAIN_LOAD) begin
                    state_d      = S_AMP_SHIFT;
                    gain_pend_d  = 1'b0;
                    start_pend_d = START;
                    if (GAIN_LOAD) begin
                        gain_d   = GAIN;
                        amp_sr_d = GAIN;
                    end else begin
                        amp_sr_d = gain_q;
                    end
                end else if (START) begin
                    state_d = S_CONV;
                    sh0_d   = 14'd0;
                    sh1_d   = 14'd0;
                end
            end

            S_AMP_SHIFT: begin
                if (div_last) begin
                    div_d = 8'd0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // End of the high half: next MOSI bit appears with the new low half.
                        phase_d  = 1'b0;
                        amp_sr_d = {amp_sr_q[6:0], 1'b0};
                        if (bit_q >= 6'd7) begin
                            state_d = S_AMP_TAIL;
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end
            end

            S_AMP_TAIL: begin
                if (div_last) begin
                    div_d = 8'd0;
                    if (start_pend_q) begin
                        state_d      = S_CONV;
                        start_pend_d = 1'b0;
                        sh0_d        = 14'd0;
                        sh1_d        = 14'd0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_CONV: begin
                if (div_last) begin
                    div_d   = 8'd0;
                    phase_d = 1'b0;
                    bit_d   = 6'd0;
                    state_d = S_ADC_SHIFT;
                end
            end

            S_ADC_SHIFT: begin
                if (div_last) begin
                    div_d = 8'd0;
                    if (!phase_q) begin
                        // This edge raises SCK, so MISO is captured here.
                        phase_d = 1'b1;
                        if (bit_q >= 6'd2 && bit_q <= 6'd15) begin
                            sh0_d = {sh0_q[12:0], SPI_MISO};
                        end
                        if (bit_q >= 6'd18 && bit_q <= 6'd31) begin
                            sh1_d = {sh1_q[12:0], SPI_MISO};
                        end
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q >= 6'd33) begin
                            state_d = S_DONE;
                            ch0_d   = sh0_q;
                            ch1_d   = sh1_q;
                            valid_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 6'd1;
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                div_d   = 8'd0;
            end

            default: begin
                state_d = S_IDLE;
                div_d   = 8'd0;
            end
        endcase

        // Pin values are registered from next-state so the SPI lines never glitch.
        sck_d  = ((state_d == S_AMP_SHIFT) || (state_d == S_ADC_SHIFT)) && phase_d;
        mosi_d = (state_d == S_AMP_SHIFT) ? amp_sr_d[7] : 1'b0;
        cs_n_d = !((state_d == S_AMP_SHIFT) || (state_d == S_AMP_TAIL));
        conv_d = (state_d == S_CONV);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            div_q        <= 8'd0;
            phase_q      <= 1'b0;
            bit_q        <= 6'd0;
            gain_q       <= GAIN_RESET;
            amp_sr_q     <= 8'd0;
            gain_pend_q  <= 1'b1;
            start_pend_q <= 1'b0;
            sh0_q        <= 14'd0;
            sh1_q        <= 14'd0;
            ch0_q        <= 14'd0;
            ch1_q        <= 14'd0;
            valid_q      <= 1'b0;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            conv_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            gain_q       <= gain_d;
            amp_sr_q     <= amp_sr_d;
            gain_pend_q  <= gain_pend_d;
            start_pend_q <= start_pend_d;
            sh0_q        <= sh0_d;
            sh1_q        <= sh1_d;
            ch0_q        <= ch0_d;
            ch1_q        <= ch1_d;
            valid_q      <= valid_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
            cs_n_q       <= cs_n_d;
            conv_q       <= conv_d;
            busy_q       <= busy_d;
        end
    end

    assign SPI_SCK  = sck_q;
    assign SPI_MOSI = mosi_q;
    assign AMP_CS   = cs_n_q;
    assign AMP_SHDN = 1'b0;
    assign AD_CONV  = conv_q;
    assign CH0      = ch0_q;
    assign CH1      = ch1_q;
    assign VALID    = valid_q;
    assign BUSY     = busy_q;

endmodule
